// File: rtl/relay_mode_ctrl.sv
// Relay front-end mode sequencer: picks mod_type per cycle from the
// decoded bit stream, the early-activity line and the relay role.
module relay_mode_ctrl #(
   parameter logic [3:0]  SOF_READER   = 4'hc,
   parameter logic [3:0]  SOF_TAG      = 4'hf,
   parameter int unsigned IDLE_BITS    = 16,
   parameter int unsigned EOF_ZEROS    = 16,
   parameter int unsigned GUARD_BITS   = 8,
   parameter int unsigned TIMEOUT_BITS = 4095
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       bit_tick,
   input  logic [2:0] role,
   input  logic       carrier_warn,
   input  logic       bit_in,
   output logic [2:0] mod_type,
   output logic       frame_active,
   output logic [7:0] bit_count,
   output logic       frame_done,
   output logic       timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_PREWARN,
      S_MOD,
      S_GUARD
   } state_t;

   localparam logic [19:0] SOF_MASK =
      20'((64'd1 << (IDLE_BITS + 4)) - 64'd1);
   localparam logic [19:0] EOF_MASK =
      20'((64'd1 << EOF_ZEROS) - 64'd1);
   localparam logic [11:0] TMO_MAX = 12'(TIMEOUT_BITS);
   localparam logic [7:0]  GRD_MAX = 8'(GUARD_BITS);

   state_t      state_q, state_d;
   logic [2:0]  role_q;
   logic [19:0] sh_q, sh_d;
   logic [7:0]  bc_q, bc_d;
   logic [11:0] tmo_q, tmo_d;
   logic [7:0]  grd_q, grd_d;
   logic [2:0]  mod_q, mod_d;
   logic        act_q, act_d;
   logic        done_q, done_d;
   logic        terr_q, terr_d;

   logic        is_tag, role_ok, role_chg;
   logic [2:0]  listen_code, mod_code;
   logic [3:0]  sof_nib;
   logic [19:0] sh_n;
   logic        sof_hit, eof_hit;
   logic [11:0] tmo_inc;
   logic [7:0]  bc_inc, grd_inc;

   // Role decode, shift-register look-ahead and pattern matches
   always_comb begin
      is_tag      = (role == 3'b110);
      role_ok     = (role == 3'b101) || is_tag;
      role_chg    = (role != role_q) || !role_ok;
      listen_code = is_tag ? 3'b001 : 3'b011;
      mod_code    = is_tag ? 3'b010 : 3'b100;
      sof_nib     = is_tag ? SOF_TAG : SOF_READER;
      sh_n        = {sh_q[18:0], bit_in};
      sof_hit     = bit_tick &&
                    ((sh_n & SOF_MASK) == {16'h0, sof_nib});
      eof_hit     = bit_tick && ((sh_n & EOF_MASK) == 20'h0) &&
                    (bc_q[1:0] == 2'b11);
      tmo_inc     = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 12'd1;
      bc_inc      = (bc_q == 8'hff) ? bc_q : bc_q + 8'd1;
      grd_inc     = grd_q + 8'd1;
   end

   // Next state, counters and registered outputs
   always_comb begin
      state_d = state_q;
      sh_d    = bit_tick ? sh_n : sh_q;
      bc_d    = bc_q;
      tmo_d   = tmo_q;
      grd_d   = grd_q;
      terr_d  = terr_q;
      done_d  = 1'b0;
      mod_d   = 3'b000;
      act_d   = 1'b0;
      if (role_chg) begin
         state_d = S_IDLE;
         sh_d    = 20'h0;
         bc_d    = 8'h0;
         tmo_d   = 12'h0;
         grd_d   = 8'h0;
         terr_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: state_d = S_ARMED;
            S_ARMED: begin
               if (sof_hit) begin
                  state_d = S_MOD;
                  bc_d    = 8'h0;
                  tmo_d   = 12'h0;
               end else if (carrier_warn) begin
                  state_d = S_PREWARN;
                  tmo_d   = 12'h0;
               end
            end
            S_PREWARN: begin
               if (sof_hit) begin
                  state_d = S_MOD;
                  bc_d    = 8'h0;
                  tmo_d   = 12'h0;
               end else if (bit_tick) begin
                  tmo_d = tmo_inc;
                  if (tmo_inc == TMO_MAX) begin
                     terr_d  = 1'b1;
                     state_d = S_ARMED;
                  end
               end
            end
            S_MOD: begin
               if (bit_tick) begin
                  bc_d  = bc_inc;
                  tmo_d = tmo_inc;
                  if (eof_hit) begin
                     done_d  = 1'b1;
                     state_d = S_GUARD;
                     grd_d   = 8'h0;
                  end else if (tmo_inc == TMO_MAX) begin
                     terr_d  = 1'b1;
                     state_d = S_GUARD;
                     grd_d   = 8'h0;
                  end
               end
            end
            S_GUARD: begin
               if (bit_tick) begin
                  if (grd_inc >= GRD_MAX) begin
                     sh_d    = 20'h0;
                     state_d = S_ARMED;
                  end else begin
                     grd_d = grd_inc;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      unique case (state_d)
         S_ARMED: mod_d = listen_code;
         S_MOD:   mod_d = mod_code;
         S_GUARD: mod_d = listen_code;
         default: mod_d = 3'b000;
      endcase
      act_d = (state_d == S_MOD);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         role_q  <= 3'b000;
         sh_q    <= 20'h0;
         bc_q    <= 8'h0;
         tmo_q   <= 12'h0;
         grd_q   <= 8'h0;
         mod_q   <= 3'b000;
         act_q   <= 1'b0;
         done_q  <= 1'b0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         role_q  <= role;
         sh_q    <= sh_d;
         bc_q    <= bc_d;
         tmo_q   <= tmo_d;
         grd_q   <= grd_d;
         mod_q   <= mod_d;
         act_q   <= act_d;
         done_q  <= done_d;
         terr_q  <= terr_d;
      end
   end

   assign mod_type     = mod_q;
   assign frame_active = act_q;
   assign bit_count    = bc_q;
   assign frame_done   = done_q;
   assign timeout_err  = terr_q;

endmodule
